// File: rtl/samm_seq_ctrl.sv
// Sequencer for a DIM x DIM systolic multiply-accumulate array: clears the grid,
// streams column k of A / row k of B with per-lane skew, drains, then steps readout rows.
module samm_seq_ctrl #(
  parameter int N   = 8,
  parameter int DIM = 4,
  parameter int KW  = 8,
  parameter int RW  = 2
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [KW-1:0]      K,
  output logic               Busy,
  output logic               Done,
  output logic               Rd_En,
  output logic [KW-1:0]      Rd_Addr,
  input  logic [DIM*N-1:0]   A_Col_Data,
  input  logic [DIM*N-1:0]   B_Row_Data,
  output logic [DIM*N-1:0]   A_Feed,
  output logic [DIM*N-1:0]   B_Feed,
  output logic               Sclr,
  output logic               Res_Valid,
  output logic [RW-1:0]      Res_Row
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

  localparam int DRAIN_LEN = 2 * DIM;
  // One shared step counter covers the operand index, the drain wait and the row select.
  localparam int CW = (KW > $clog2(DRAIN_LEN)) ? KW : $clog2(DRAIN_LEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [KW-1:0]   k_lat;
  logic            rd_vld;
  logic [DIM*N-1:0] a_in, b_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k_lat  <= '0;
      rd_vld <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rd_vld <= Rd_En;
      if (state == S_IDLE && Start) k_lat <= K;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Busy      = 1'b0;
    Done      = 1'b0;
    Rd_En     = 1'b0;
    Rd_Addr   = '0;
    Sclr      = 1'b1;
    Res_Valid = 1'b0;
    Res_Row   = '0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        Busy      = 1'b1;
        Sclr      = 1'b0;
        cnt_nxt   = '0;
        state_nxt = (k_lat != '0) ? S_FEED : S_READOUT;
      end
      S_FEED: begin
        Busy    = 1'b1;
        Rd_En   = 1'b1;
        Rd_Addr = cnt[KW-1:0];
        if (cnt == CW'(k_lat) - CW'(1)) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        Busy = 1'b1;
        if (cnt == CW'(DRAIN_LEN - 1)) begin
          state_nxt = S_READOUT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_READOUT: begin
        Busy      = 1'b1;
        Res_Valid = 1'b1;
        Res_Row   = cnt[RW-1:0];
        if (cnt == CW'(DIM - 1)) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Zero is injected whenever the buffer output is stale, so feeds are 0 outside the operand window.
  assign a_in = rd_vld ? A_Col_Data : '0;
  assign b_in = rd_vld ? B_Row_Data : '0;

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign A_Feed[N-1:0] = a_in[N-1:0];
      assign B_Feed[N-1:0] = b_in[N-1:0];
    end else begin : g_skew
      logic [N-1:0] a_sr [i];
      logic [N-1:0] b_sr [i];

      // NOTE: the skew stages are ordinary flops, reset so the feeds are clean zeros out of reset.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_in[i*N +: N];
          b_sr[0] <= b_in[i*N +: N];
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end

      assign A_Feed[i*N +: N] = a_sr[i-1];
      assign B_Feed[i*N +: N] = b_sr[i-1];
    end
  end

endmodule

// File: tb/tb_samm_seq_ctrl.sv
// Bench for samm_seq_ctrl: operand-buffer model, behavioural PE grid, and cycle-by-cycle
// expectations derived from the job timeline and the matrix product A*B.
module tb_samm_seq_ctrl;

  localparam int N   = 8;
  localparam int DIM = 4;
  localparam int KW  = 8;
  localparam int RW  = 2;

  logic               Clk = 1'b0;
  logic               Rst_n;
  logic               Start;
  logic [KW-1:0]      K;
  logic               Busy, Done, Rd_En, Sclr, Res_Valid;
  logic [KW-1:0]      Rd_Addr;
  logic [DIM*N-1:0]   A_Col_Data, B_Row_Data, A_Feed, B_Feed;
  logic [RW-1:0]      Res_Row;

  int total = 0;
  int bad   = 0;

  logic [N-1:0]   amat [DIM][256];
  logic [N-1:0]   bmat [256][DIM];
  logic [2*N-1:0] acc  [DIM][DIM];
  logic [N-1:0]   pa   [DIM][DIM];
  logic [N-1:0]   pb   [DIM][DIM];

  samm_seq_ctrl #(.N(N), .DIM(DIM), .KW(KW), .RW(RW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .K(K),
    .Busy(Busy), .Done(Done), .Rd_En(Rd_En), .Rd_Addr(Rd_Addr),
    .A_Col_Data(A_Col_Data), .B_Row_Data(B_Row_Data),
    .A_Feed(A_Feed), .B_Feed(B_Feed), .Sclr(Sclr),
    .Res_Valid(Res_Valid), .Res_Row(Res_Row)
  );

  always #5 Clk = ~Clk;

  // Operand buffers: registered read, junk on the bus whenever no read was issued.
  always @(posedge Clk) begin
    for (int i = 0; i < DIM; i++) begin
      A_Col_Data[i*N +: N] <= Rd_En ? amat[i][Rd_Addr] : N'($urandom);
      B_Row_Data[i*N +: N] <= Rd_En ? bmat[Rd_Addr][i] : N'($urandom);
    end
  end

  function automatic logic [N-1:0] pe_a(int i, int j);
    if (j == 0) return A_Feed[i*N +: N];
    return pa[i][j-1];
  endfunction

  function automatic logic [N-1:0] pe_b(int i, int j);
    if (i == 0) return B_Feed[j*N +: N];
    return pb[i-1][j];
  endfunction

  function automatic logic [2*N-1:0] mul(logic [N-1:0] a, logic [N-1:0] b);
    logic [2*N-1:0] x;
    x = (2*N)'(a);
    return x * (2*N)'(b);
  endfunction

  // PE grid: A moves east, B moves south, each PE accumulates a*b; Sclr low clears everything.
  always @(posedge Clk) begin
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (!Sclr) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + mul(pe_a(i, j), pe_b(i, j));
          pa[i][j]  <= pe_a(i, j);
          pb[i][j]  <= pe_b(i, j);
        end
      end
    end
  end

  function automatic logic [2*N-1:0] exp_c(int i, int j, int k);
    logic [2*N-1:0] s;
    s = '0;
    for (int kk = 0; kk < k; kk++) s = s + mul(amat[i][kk], bmat[kk][j]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: random, 1: all ones, 2: the 2x2 example embedded in the top-left corner
  task automatic fill(input int mode);
    for (int kk = 0; kk < 256; kk++) begin
      for (int i = 0; i < DIM; i++) begin
        amat[i][kk] = (mode == 0) ? N'($urandom) : (mode == 1) ? N'(1) : '0;
        bmat[kk][i] = (mode == 0) ? N'($urandom) : (mode == 1) ? N'(1) : '0;
      end
    end
    if (mode == 2) begin
      amat[0][0] = 1; amat[0][1] = 2; amat[1][0] = 3; amat[1][1] = 4;
      bmat[0][0] = 5; bmat[0][1] = 6; bmat[1][0] = 7; bmat[1][1] = 8;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      64'(Busy),      64'(0));
    check({tag, " done"},      64'(Done),      64'(0));
    check({tag, " rd_en"},     64'(Rd_En),     64'(0));
    check({tag, " rd_addr"},   64'(Rd_Addr),   64'(0));
    check({tag, " a_feed"},    64'(A_Feed),    64'(0));
    check({tag, " b_feed"},    64'(B_Feed),    64'(0));
    check({tag, " sclr"},      64'(Sclr),      64'(1));
    check({tag, " res_valid"}, 64'(Res_Valid), 64'(0));
    check({tag, " res_row"},   64'(Res_Row),   64'(0));
  endtask

  // Entered at the falling edge of an IDLE cycle (cycle 0); leaves at the falling edge
  // of the IDLE cycle after DONE. Start is pulsed again at cycle poke, or held if hold=1.
  task automatic run_job(input int k, input int poke, input bit hold);
    int rs, re, dn, kk;
    logic [N-1:0] ea, eb;
    rs = (k == 0) ? 2 : k + 2 + 2 * DIM;
    re = rs + DIM - 1;
    dn = re + 1;
    Start = 1'b1;
    K     = KW'(k);
    @(posedge Clk);
    for (int c = 1; c <= dn; c++) begin
      @(negedge Clk);
      Start = hold || (c == poke);
      K     = KW'($urandom);
      check($sformatf("k%0d c%0d busy", k, c),  64'(Busy),  64'(c < dn));
      check($sformatf("k%0d c%0d done", k, c),  64'(Done),  64'(c == dn));
      check($sformatf("k%0d c%0d sclr", k, c),  64'(Sclr),  64'(c != 1));
      check($sformatf("k%0d c%0d rd_en", k, c), 64'(Rd_En), 64'(c >= 2 && c <= k + 1));
      if (c >= 2 && c <= k + 1)
        check($sformatf("k%0d c%0d rd_addr", k, c), 64'(Rd_Addr), 64'(c - 2));
      check($sformatf("k%0d c%0d res_valid", k, c), 64'(Res_Valid), 64'(c >= rs && c <= re));
      for (int i = 0; i < DIM; i++) begin
        kk = c - 3 - i;
        ea = '0;
        eb = '0;
        if (kk >= 0 && kk < k) begin
          ea = amat[i][kk];
          eb = bmat[kk][i];
        end
        check($sformatf("k%0d c%0d a_feed%0d", k, c, i), 64'(A_Feed[i*N +: N]), 64'(ea));
        check($sformatf("k%0d c%0d b_feed%0d", k, c, i), 64'(B_Feed[i*N +: N]), 64'(eb));
      end
      if (c >= rs && c <= re) begin
        check($sformatf("k%0d c%0d res_row", k, c), 64'(Res_Row), 64'(c - rs));
        for (int j = 0; j < DIM; j++)
          check($sformatf("k%0d c%0d C[%0d][%0d]", k, c, c - rs, j),
                64'(acc[c-rs][j]), 64'(exp_c(c - rs, j, k)));
      end
    end
    @(negedge Clk);
    check($sformatf("k%0d idle busy", k),  64'(Busy),  64'(0));
    check($sformatf("k%0d idle done", k),  64'(Done),  64'(0));
    check($sformatf("k%0d idle sclr", k),  64'(Sclr),  64'(1));
    check($sformatf("k%0d idle rd_en", k), 64'(Rd_En), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    K     = '0;
    fill(0);
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    check_reset_outputs("idle after reset");

    // Basic 2x2 job embedded in the array
    fill(2);
    run_job(2, 0, 1'b0);
    check("basic C00", 64'(acc[0][0]), 64'(19));
    check("basic C01", 64'(acc[0][1]), 64'(22));
    check("basic C10", 64'(acc[1][0]), 64'(43));
    check("basic C11", 64'(acc[1][1]), 64'(50));

    // Skew with all-ones operands, K=1
    fill(1);
    run_job(1, 0, 1'b0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        check($sformatf("ones C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(1));

    // K=0: straight to readout, all-zero product
    fill(0);
    run_job(0, 0, 1'b0);
    for (int i = 0; i < DIM; i++)
      check($sformatf("k0 C[%0d][%0d]", i, i), 64'(acc[i][i]), 64'(0));

    // Start pulsed again mid-job is ignored
    fill(0);
    run_job(3, 4, 1'b0);

    // Reset in the middle of FEED of a K=8 job
    fill(0);
    Start = 1'b1;
    K     = 8'd8;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("midfeed rd_en before reset", 64'(Rd_En), 64'(1));
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("midfeed reset");
    repeat (3) begin
      @(negedge Clk);
      check_reset_outputs("midfeed held");
    end
    Rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      check($sformatf("post reset c%0d done", c), 64'(Done), 64'(0));
      check($sformatf("post reset c%0d busy", c), 64'(Busy), 64'(0));
    end
    fill(0);
    run_job(5, 0, 1'b0);

    // Back-to-back with Start held across the first job
    fill(0);
    run_job(2, 0, 1'b1);
    fill(0);
    run_job(2, 0, 1'b0);

    // Randomized jobs, including occasional stray Start pulses
    for (int n = 0; n < 8; n++) begin
      fill(0);
      run_job(int'($urandom_range(12, 0)), int'($urandom_range(20, 2)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
